// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage pipeline. Strobes are combinational from the state and inputs,
// with zero latency; only the state, vcnt and hold_count are registered. A load-use stall inserts one bubble.
module pipeline_control #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_fwd,
    input  logic              branch_taken_ex,
    input  logic              vop_start,
    input  logic [CNT_W-1:0]  vop_cycles,
    input  logic              mem_wait,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              vbusy,
    output logic [PERF_W-1:0] hold_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SHADOW = 2'd1,
        ST_VBUSY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   vcnt_q, vcnt_d;
    logic [PERF_W-1:0]  hold_count_q, hold_count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            vcnt_q       <= '0;
            hold_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vcnt_q       <= vcnt_d;
            hold_count_q <= hold_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vcnt_d      = vcnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (mem_wait) begin
            // Freeze everything upstream of WB; WB drains a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (state_q == ST_VBUSY) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            if (vcnt_q == CNT_W'(1)) begin
                state_d = ST_RUN;
                vcnt_d  = '0;
            end else begin
                vcnt_d  = vcnt_q - CNT_W'(1);
            end
        end else if (stall_fwd && (state_q == ST_RUN)) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = ST_SHADOW;
        end else if (vop_start && (vop_cycles >= CNT_W'(2))) begin
            // The start cycle is the first of the N-1 hold cycles.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            if (vop_cycles >= CNT_W'(3)) begin
                state_d = ST_VBUSY;
                vcnt_d  = vop_cycles - CNT_W'(2);
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            if (branch_taken_ex) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            // SHADOW lasts exactly one cycle.
            state_d = ST_RUN;
        end

        // Reset overrides every strobe immediately, without waiting for a clock.
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end

        hold_count_d = hold_count_q;
        if (!pc_en && (hold_count_q != {PERF_W{1'b1}})) begin
            hold_count_d = hold_count_q + PERF_W'(1);
        end
    end

    assign vbusy      = (state_q == ST_VBUSY);
    assign hold_count = hold_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed scenarios plus random traffic against a hold-budget reference model.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_fwd, branch_taken_ex, vop_start, mem_wait;
    logic [3:0]  vop_cycles;

    logic        d_pc, d_ifid, d_idex, d_exmem, d_memwb;
    logic        d_ifidf, d_idexf, d_exmemf, d_memwbf, d_vbusy;
    logic [15:0] d_hold;
    logic        s_pc, s_ifid, s_idex, s_exmem, s_memwb;
    logic        s_ifidf, s_idexf, s_exmemf, s_memwbf, s_vbusy;
    logic [3:0]  s_hold;

    logic [9:0]  d_vec, s_vec;
    assign d_vec = {d_pc, d_ifid, d_idex, d_exmem, d_memwb, d_ifidf, d_idexf, d_exmemf, d_memwbf, d_vbusy};
    assign s_vec = {s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_ifidf, s_idexf, s_exmemf, s_memwbf, s_vbusy};

    int errors = 0;
    int checks = 0;

    // Reference model: pending hold cycles of a vector op, load-use shadow flag, stall-cycle count.
    int hold_left;
    bit shadow;
    int hcnt;

    always #5 clk = ~clk;

    pipeline_control #(.CNT_W(4), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .stall_fwd(stall_fwd), .branch_taken_ex(branch_taken_ex),
        .vop_start(vop_start), .vop_cycles(vop_cycles), .mem_wait(mem_wait),
        .pc_en(d_pc), .ifid_en(d_ifid), .idex_en(d_idex), .exmem_en(d_exmem), .memwb_en(d_memwb),
        .ifid_flush(d_ifidf), .idex_flush(d_idexf), .exmem_flush(d_exmemf), .memwb_flush(d_memwbf),
        .vbusy(d_vbusy), .hold_count(d_hold)
    );

    pipeline_control #(.CNT_W(4), .PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_fwd(stall_fwd), .branch_taken_ex(branch_taken_ex),
        .vop_start(vop_start), .vop_cycles(vop_cycles), .mem_wait(mem_wait),
        .pc_en(s_pc), .ifid_en(s_ifid), .idex_en(s_idex), .exmem_en(s_exmem), .memwb_en(s_memwb),
        .ifid_flush(s_ifidf), .idex_flush(s_idexf), .exmem_flush(s_exmemf), .memwb_flush(s_memwbf),
        .vbusy(s_vbusy), .hold_count(s_hold)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hold_left = 0;
        shadow    = 0;
        hcnt      = 0;
    endtask

    task automatic drive(input logic sf, input logic br, input logic vs, input logic [3:0] vc, input logic mw);
        stall_fwd       = sf;
        branch_taken_ex = br;
        vop_start       = vs;
        vop_cycles      = vc;
        mem_wait        = mw;
    endtask

    // One clock cycle: drive inputs, check the combinational strobes, then advance the model.
    task automatic step(input logic sf, input logic br, input logic vs, input logic [3:0] vc, input logic mw);
        logic [4:0] en;
        logic [3:0] fl;
        logic       busy;
        logic       lst;
        @(negedge clk);
        drive(sf, br, vs, vc, mw);
        #1;
        en   = 5'b11111;
        fl   = 4'b0000;
        busy = (hold_left > 0);
        lst  = 1'b0;
        if (mw) begin
            en = 5'b00001; fl = 4'b0001;
        end else if (busy) begin
            en = 5'b00011; fl = 4'b0010; hold_left--;
        end else if (sf && !shadow) begin
            en = 5'b00011; fl = 4'b0010; lst = 1'b1;
        end else if (vs && (vc >= 4'd2)) begin
            en = 5'b00011; fl = 4'b0010; hold_left = int'(vc) - 2;
        end else if (br) begin
            fl = 4'b1100;
        end
        chk("strobes", 32'(d_vec), 32'({en, fl, busy}));
        chk("strobes_p4", 32'(s_vec), 32'({en, fl, busy}));
        chk("hold16", 32'(d_hold), 32'((hcnt > 65535) ? 65535 : hcnt));
        chk("hold4", 32'(s_hold), 32'((hcnt > 15) ? 15 : hcnt));
        if (!mw) shadow = lst;
        if (!en[4]) hcnt++;
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_strobes"}, 32'(d_vec), 32'(10'b00000_1111_0));
        chk({tag, "_hold16"}, 32'(d_hold), 32'd0);
        chk({tag, "_hold4"}, 32'(s_hold), 32'd0);
    endtask

    // Reset is pulled low mid-cycle to show it acts without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 4'd0, 0);
        #2 rst = 1'b0;
        #1 check_in_reset("rst_async");
        @(posedge clk);
        #1 check_in_reset("rst_held");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 4'd0, 0);
        model_reset();
        do_reset();
        step(0, 0, 0, 4'd0, 0);

        // Load-use held for two cycles: only one bubble.
        step(1, 0, 0, 4'd0, 0);
        step(1, 0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("loaduse_hold", 32'(d_hold), 32'd1);

        // Vector op N=4, then N=2.
        step(0, 0, 1, 4'd4, 0);
        step(0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("vop4_hold", 32'(d_hold), 32'd4);
        step(0, 0, 1, 4'd2, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("vop2_hold", 32'(d_hold), 32'd5);

        // Stall and branch together, then branch alone in the shadow cycle.
        step(1, 1, 0, 4'd0, 0);
        step(0, 1, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("stallbr_hold", 32'(d_hold), 32'd6);

        // N=5 vector op with two mem_wait cycles inside VBUSY: six hold cycles.
        step(0, 0, 1, 4'd5, 0);
        step(0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 1);
        step(0, 0, 0, 4'd0, 1);
        step(0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 4'd0, 0);
        chk("memvbusy_hold", 32'(d_hold), 32'd12);

        // Reset in the middle of a vector op.
        step(0, 0, 1, 4'd6, 0);
        step(0, 0, 0, 4'd0, 0);
        do_reset();
        step(0, 0, 0, 4'd0, 0);

        // Saturation of the narrow counter.
        repeat (20) step(0, 0, 0, 4'd0, 1);
        step(0, 0, 0, 4'd0, 0);
        chk("sat_hold4", 32'(s_hold), 32'd15);
        chk("sat_hold16", 32'(d_hold), 32'd20);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 6) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the interpolation ASIP's five-stage pipeline. It consumes the combinational `stall` from the forwarding unit, branch resolution from EX, multi-cycle vector-op starts, and the data-memory wait. It drives the enable and flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM limits each load-use stall to exactly one bubble and holds EX for the duration of a multi-cycle vector operation.

## Interface
- `CNT_W`, 4: width of `vop_cycles`
- `PERF_W`, 16: width of saturating `hold_count`
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous reset, active-low
- `stall_fwd`  in  1  load-use stall from the forwarding unit; combinational, same cycle
- `branch_taken_ex`  in  1  branch in EX resolved taken
- `vop_start`  in  1  multi-cycle vector op is in EX this cycle
- `vop_cycles`  in  CNT_W  total EX occupancy N of that op; sampled only with `vop_start`
- `mem_wait`  in  1  data memory not ready; level-sensitive
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register load enables
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load a bubble (write-enables cleared) instead of data
- `vbusy`  out  1  FSM in VBUSY
- `hold_count`  out  PERF_W  cycles with `pc_en`=0 since reset; saturates at all-ones

## Operation
- Outputs are combinational from the registered state and the current inputs. State, `vcnt` (CNT_W) and `hold_count` are registered.
- States:
  - RUN
  - SHADOW: the cycle after a load-use stall; `stall_fwd` is ignored
  - VBUSY: EX held for a vector op
- Default strobes: all enables 1, all flushes 0.
- Action priority, highest first:
  - MEMWAIT, when `mem_wait`=1 (any state):
    - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0
    - `memwb_en`=1, `memwb_flush`=1
    - State and `vcnt` are frozen.
  - VHOLD, when state is VBUSY:
    - `pc_en`, `ifid_en`, `idex_en` = 0
    - `exmem_flush`=1
    - If `vcnt`==1, go to RUN; otherwise `vcnt`--.
    - `branch_taken_ex`, `stall_fwd` and `vop_start` are ignored.
  - LSTALL, when `stall_fwd`=1 in RUN:
    - `pc_en`, `ifid_en`, `idex_en` = 0
    - `exmem_flush`=1
    - Go to SHADOW.
    - Overrides `branch_taken_ex` and `vop_start`; both are re-evaluated once the op re-presents.
  - VSTART, when `vop_start`=1 and N≥2 (RUN or SHADOW):
    - Same strobes as VHOLD.
    - If N≥3, go to VBUSY with `vcnt`=N−2; if N==2, stay in (or return to) RUN.
    - N∈{0,1}: no hold, treated as a normal instruction.
  - BRANCH, when `branch_taken_ex`=1 (RUN or SHADOW):
    - `pc_en`=1 (PC loads the target)
    - `ifid_flush`=1, `idex_flush`=1
    - May occur in the same cycle as VSTART's successor instruction; no state change.
  - NORMAL: default strobes; SHADOW returns to RUN.
- A vector op of N cycles produces exactly N−1 hold cycles, counting its start cycle.
- `hold_count` increments whenever `pc_en`=0 and `rst`=1; it holds at 2^PERF_W−1.

## Timing
- Reset (`rst`=0, immediate, asynchronous):
  - All enables 0, all flushes 1, `vbusy`=0, `hold_count`=0.
  - State RUN, `vcnt`=0.
  - Applies mid-VBUSY or mid-MEMWAIT as well.
- First rising edge after `rst` deasserts: default strobes.
- Strobes respond to inputs in the same cycle with zero latency. State effects appear from the next edge.
- Load-use: one bubble only. If `stall_fwd` stays high into the SHADOW cycle, it is ignored.
- `vbusy` rises one cycle after VSTART and falls on the edge following the `vcnt`==1 cycle.
- A MEMWAIT inside VBUSY extends the hold by exactly the number of `mem_wait` cycles.

## Test plan
- Reset: `rst`=0 mid-VBUSY → all enables 0, flushes 1, `vbusy`=0 and `hold_count`=0 immediately. Release → default strobes on the next cycle.
- Load-use: `stall_fwd`=1 for 2 cycles → cycle 1 has `pc_en`=0 and `exmem_flush`=1; cycle 2 has default strobes. `hold_count`=1.
- Vector op: `vop_start`=1, `vop_cycles`=4 → `pc_en`=0 for 3 cycles, `vbusy`=1 on cycles 2–3, RUN on cycle 4, `hold_count`=3. Repeat with N=2: one hold cycle and `vbusy` never set.
- Stall+branch: `stall_fwd`=1 and `branch_taken_ex`=1 together → LSTALL strobes with `ifid_flush`=0. Next cycle with branch only → `ifid_flush`=`idex_flush`=1 and `pc_en`=1.
- Memwait in VBUSY: N=5, `mem_wait`=1 for 2 cycles during VBUSY → `memwb_flush`=1 on those cycles, `vcnt` frozen, total `pc_en`=0 cycles = 6.
- Saturation: `PERF_W`=4, `mem_wait` high 20 cycles → `hold_count`=15 and stays at 15.
